// File: rtl/mem_arbiter_if.sv
// CPU / video / SRAM signal bundle for the shared memory arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if;
  logic [23:0] cpu_adr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_ben;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        vid_req;
  logic [21:0] vid_adr;
  logic        vid_ack;
  logic [31:0] vid_data;
  logic [21:0] mem_adr;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata,
    input  vid_req, vid_adr, mem_rdata,
    output cpu_rdata, cpu_stall, vid_ack, vid_data,
    output mem_adr, mem_ce, mem_we, mem_be, mem_wdata
  );

  modport master (
    output cpu_adr, cpu_rd, cpu_wr, cpu_ben, cpu_wdata,
    output vid_req, vid_adr, mem_rdata,
    input  cpu_rdata, cpu_stall, vid_ack, vid_data,
    input  mem_adr, mem_ce, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one word-wide SRAM between CPU load/store and video refresh.
// Video wins until VID_BURST grants pass with the CPU still waiting.
module mem_arbiter #(
  parameter int unsigned MEM_WAIT  = 1,
  parameter int unsigned VID_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_VID} owner_e;

  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);
  localparam logic [3:0] BURST     = 4'(VID_BURST);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  vcount_q, vcount_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [21:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] crd_q, crd_d;
  logic [31:0] vdat_q, vdat_d;

  logic       cpu_req;
  logic       grant_vid;
  logic       grant_cpu;
  logic [3:0] lane_be;

  assign cpu_req = bus.cpu_rd | bus.cpu_wr;

  always_comb begin
    lane_be = 4'b0001;
    unique case (bus.cpu_adr[1:0])
      2'd0: lane_be = 4'b0001;
      2'd1: lane_be = 4'b0010;
      2'd2: lane_be = 4'b0100;
      2'd3: lane_be = 4'b1000;
    endcase
  end

  // Priority order: video under burst limit, CPU, then video again.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == IDLE) begin
      if (bus.vid_req && (vcount_q < BURST))
        grant_vid = 1'b1;
      else if (cpu_req)
        grant_cpu = 1'b1;
      else if (bus.vid_req)
        grant_vid = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    vcount_d = vcount_q;
    wcnt_d   = wcnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    crd_d    = crd_q;
    vdat_d   = vdat_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vid || grant_cpu) begin
          state_d = ACCESS;
          wcnt_d  = WAIT_INIT;
          wdata_d = bus.cpu_wdata;
          owner_d = grant_vid ? OWN_VID : OWN_CPU;
          adr_d   = grant_vid ? bus.vid_adr
                              : bus.cpu_adr[23:2];
          we_d    = grant_cpu & bus.cpu_wr;
          be_d    = (grant_vid | ~bus.cpu_ben)
                    ? 4'b1111 : lane_be;
          if (grant_cpu)
            vcount_d = 4'd0;
          else if (vcount_q < BURST)
            vcount_d = vcount_q + 4'd1;
        end else begin
          vcount_d = 4'd0;
        end
      end
      ACCESS: begin
        if (wcnt_q == 3'd0) begin
          state_d = DONE;
          if (owner_q == OWN_VID)
            vdat_d = bus.mem_rdata;
          else if (!we_q)
            crd_d = bus.mem_rdata;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_CPU;
      vcount_q <= 4'd0;
      wcnt_q   <= 3'd0;
      adr_q    <= 22'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      crd_q    <= 32'd0;
      vdat_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      vcount_q <= vcount_d;
      wcnt_q   <= wcnt_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      crd_q    <= crd_d;
      vdat_q   <= vdat_d;
    end
  end

  assign bus.mem_ce    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) & we_q;
  assign bus.mem_adr   = adr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = crd_q;
  assign bus.vid_data  = vdat_q;
  assign bus.vid_ack   = (state_q == DONE) && (owner_q == OWN_VID);
  assign bus.cpu_stall = cpu_req &
    ~((state_q == DONE) && (owner_q == OWN_CPU));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: CPU access table, video burst,
// video stream, reset mid-access and a zero-wait-state instance.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if b0();
  mem_arbiter_if b1();

  mem_arbiter u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mem_arbiter #(.MEM_WAIT(0)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h41) return 32'hDEADBEEF;
    if (i == 32'h80) return 32'h11223344;
    return 32'h5A000000 ^ (32'(i) * 32'h00010003);
  endfunction

  logic [31:0] ram0 [0:1023];
  logic [31:0] ram1 [0:1023];

  assign b0.mem_rdata = ram0[b0.mem_adr[9:0]];
  assign b1.mem_rdata = ram1[b1.mem_adr[9:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) begin
        ram0[i] <= init_word(i);
        ram1[i] <= init_word(i);
      end
    end else begin
      if (b0.mem_ce && b0.mem_we)
        for (int k = 0; k < 4; k++)
          if (b0.mem_be[k])
            ram0[b0.mem_adr[9:0]][k*8 +: 8] <= b0.mem_wdata[k*8 +: 8];
      if (b1.mem_ce && b1.mem_we)
        for (int k = 0; k < 4; k++)
          if (b1.mem_be[k])
            ram1[b1.mem_adr[9:0]][k*8 +: 8] <= b1.mem_wdata[k*8 +: 8];
    end
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] adr;
    logic        rd;
    logic        wr;
    logic        ben;
    logic [31:0] wd;
    logic [21:0] exp_adr;
    logic [3:0]  exp_be;
    int          exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [9];

  // One CPU access on u0; returns what was observed on the RAM pins.
  task automatic cpu_op(input vec_t v, output logic [31:0] rdata,
                        output int st, output int ce, output int we,
                        output logic [3:0] be, output logic [21:0] adr,
                        output logic [31:0] wd, output bit done);
    st = 0; ce = 0; we = 0; be = 4'h0; adr = 22'h0; wd = 32'h0;
    rdata = 32'h0; done = 1'b0;
    @(posedge clk); #1;
    b0.cpu_adr = v.adr; b0.cpu_rd = v.rd; b0.cpu_wr = v.wr;
    b0.cpu_ben = v.ben; b0.cpu_wdata = v.wd;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (b0.mem_ce) begin
        ce++;
        if (b0.mem_we) we++;
        be = b0.mem_be; adr = b0.mem_adr; wd = b0.mem_wdata;
      end
      if (b0.cpu_stall) st++;
      else begin rdata = b0.cpu_rdata; done = 1'b1; end
    end
    @(posedge clk); #1;
    b0.cpu_rd = 1'b0; b0.cpu_wr = 1'b0;
  endtask

  logic [31:0] rd_v, wd_v;
  logic [3:0]  be_v;
  logic [21:0] adr_v;
  int          st_v, ce_v, we_v, nack, cpu_c, nstall;
  bit          done_v, ack, cdone;

  initial begin
    n_chk = 0; n_fail = 0;
    vt[0] = '{24'h000104, 1'b1, 1'b0, 1'b0, 32'h0,
              22'h041, 4'b1111, 0, 32'hDEADBEEF};
    vt[1] = '{24'h000203, 1'b0, 1'b1, 1'b1, 32'h77777777,
              22'h080, 4'b1000, 2, 32'hDEADBEEF};
    vt[2] = '{24'h000200, 1'b1, 1'b0, 1'b0, 32'h0,
              22'h080, 4'b1111, 0, 32'h77223344};
    vt[3] = '{24'h000200, 1'b0, 1'b1, 1'b1, 32'h000000AA,
              22'h080, 4'b0001, 2, 32'h77223344};
    vt[4] = '{24'h000201, 1'b0, 1'b1, 1'b1, 32'h0000BB00,
              22'h080, 4'b0010, 2, 32'h77223344};
    vt[5] = '{24'h000202, 1'b0, 1'b1, 1'b1, 32'h00CC0000,
              22'h080, 4'b0100, 2, 32'h77223344};
    vt[6] = '{24'h000200, 1'b1, 1'b0, 1'b1, 32'h0,
              22'h080, 4'b0001, 0, 32'h77CCBBAA};
    vt[7] = '{24'h000300, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D,
              22'h0C0, 4'b1111, 2, 32'h77CCBBAA};
    vt[8] = '{24'h000300, 1'b1, 1'b0, 1'b0, 32'h0,
              22'h0C0, 4'b1111, 0, 32'hCAFEF00D};

    rst = 1'b1;
    b0.cpu_adr = 24'h0; b0.cpu_rd = 1'b0; b0.cpu_wr = 1'b0;
    b0.cpu_ben = 1'b0; b0.cpu_wdata = 32'h0;
    b0.vid_req = 1'b0; b0.vid_adr = 22'h0;
    b1.cpu_adr = 24'h0; b1.cpu_rd = 1'b0; b1.cpu_wr = 1'b0;
    b1.cpu_ben = 1'b0; b1.cpu_wdata = 32'h0;
    b1.vid_req = 1'b0; b1.vid_adr = 22'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_ce", b0.mem_ce, 0);
    chk("rst_mem_we", b0.mem_we, 0);
    chk("rst_mem_be", b0.mem_be, 0);
    chk("rst_mem_adr", b0.mem_adr, 0);
    chk("rst_mem_wdata", b0.mem_wdata, 0);
    chk("rst_cpu_rdata", b0.cpu_rdata, 0);
    chk("rst_vid_data", b0.vid_data, 0);
    chk("rst_vid_ack", b0.vid_ack, 0);
    chk("rst_cpu_stall", b0.cpu_stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int n = 0; n < 9; n++) begin
      cpu_op(vt[n], rd_v, st_v, ce_v, we_v, be_v, adr_v, wd_v, done_v);
      chk($sformatf("v%0d_done", n), done_v, 1);
      chk($sformatf("v%0d_stall", n), st_v, 3);
      chk($sformatf("v%0d_ce", n), ce_v, 2);
      chk($sformatf("v%0d_we", n), we_v, vt[n].exp_we);
      chk($sformatf("v%0d_adr", n), adr_v, vt[n].exp_adr);
      chk($sformatf("v%0d_be", n), be_v, vt[n].exp_be);
      chk($sformatf("v%0d_wdata", n), wd_v, vt[n].wd);
      chk($sformatf("v%0d_rdata", n), rd_v, vt[n].exp_rdata);
    end

    // Video held with CPU pending: 8 video, CPU, video again.
    @(posedge clk); #1;
    b0.vid_adr = 22'h10; b0.vid_req = 1'b1;
    b0.cpu_adr = 24'h000104; b0.cpu_rd = 1'b1;
    b0.cpu_wr = 1'b0; b0.cpu_ben = 1'b0;
    nack = 0; cpu_c = -1;
    for (int c = 0; c < 80 && nack < 10; c++) begin
      @(negedge clk);
      ack = b0.vid_ack;
      cdone = b0.cpu_rd && !b0.cpu_stall;
      if (ack) begin
        chk("burst_vdata", b0.vid_data, init_word(int'(b0.vid_adr)));
        chk("burst_ack_cyc", c,
            (nack < 8) ? 3 + 4 * nack : 39 + 4 * (nack - 8));
        nack++;
      end
      if (cdone) begin
        chk("burst_cpu_after", nack, 8);
        chk("burst_cpu_cyc", c, 35);
        chk("burst_cpu_rdata", b0.cpu_rdata, 32'hDEADBEEF);
        cpu_c = c;
      end
      if (c == 37) chk("burst_vcount", u0.vcount_q, 1);
      @(posedge clk); #1;
      if (ack) b0.vid_adr = b0.vid_adr + 22'd1;
      if (cdone) b0.cpu_rd = 1'b0;
    end
    b0.vid_req = 1'b0;
    chk("burst_acks", nack, 10);
    chk("burst_cpu_seen", cpu_c, 35);

    // Video alone, 20 words back to back.
    @(posedge clk); #1;
    b0.vid_adr = 22'h100; b0.vid_req = 1'b1;
    nack = 0; nstall = 0;
    for (int c = 0; c < 120 && nack < 20; c++) begin
      @(negedge clk);
      ack = b0.vid_ack;
      if (b0.cpu_stall) nstall++;
      if (ack) begin
        chk("strm_vdata", b0.vid_data, init_word(int'(b0.vid_adr)));
        chk("strm_ack_cyc", c, 3 + 4 * nack);
        nack++;
      end
      @(posedge clk); #1;
      if (ack) begin
        b0.vid_adr = b0.vid_adr + 22'd1;
        if (nack == 20) b0.vid_req = 1'b0;
      end
    end
    b0.vid_req = 1'b0;
    chk("strm_acks", nack, 20);
    chk("strm_no_stall", nstall, 0);

    // Reset during the second ACCESS cycle of a video read.
    @(posedge clk); #1;
    b0.vid_adr = 22'h200; b0.vid_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstm_ce_before", b0.mem_ce, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstm_ce_2nd", b0.mem_ce, 1);
    @(posedge clk); #1;
    rst = 1'b0; b0.vid_req = 1'b0;
    @(negedge clk);
    chk("rstm_ce_after", b0.mem_ce, 0);
    chk("rstm_ack_after", b0.vid_ack, 0);
    chk("rstm_vdata", b0.vid_data, 0);
    nack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b0.vid_ack) nack++;
    end
    chk("rstm_no_ack", nack, 0);
    cpu_op(vt[0], rd_v, st_v, ce_v, we_v, be_v, adr_v, wd_v, done_v);
    chk("rstm_cpu_done", done_v, 1);
    chk("rstm_cpu_stall", st_v, 3);
    chk("rstm_cpu_rdata", rd_v, 32'hDEADBEEF);

    // Zero wait states on u1.
    @(posedge clk); #1;
    b1.cpu_adr = 24'h000104; b1.cpu_rd = 1'b1;
    ce_v = 0; st_v = 0; done_v = 1'b0; rd_v = 32'h0;
    for (int i = 0; i < 20 && !done_v; i++) begin
      @(negedge clk);
      if (b1.mem_ce) ce_v++;
      if (b1.cpu_stall) st_v++;
      else begin rd_v = b1.cpu_rdata; done_v = 1'b1; end
    end
    @(posedge clk); #1;
    b1.cpu_rd = 1'b0;
    chk("w0_done", done_v, 1);
    chk("w0_ce", ce_v, 1);
    chk("w0_stall", st_v, 2);
    chk("w0_rdata", rd_v, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one 32-bit word-organised static RAM between the RISC5 CPU's load/store port and a video refresh fetcher.
- Sits between the CPU bus and the RAM pins.
- Sequences each access through fixed wait states and holds the CPU via `cpu_stall` until its access completes.
- Video is favoured so that display refresh never starves, but a burst limit guarantees CPU forward progress.

Parameters:
- MEM_WAIT, 1, extra RAM cycles per access (legal 0..7); an access occupies the RAM for MEM_WAIT+1 cycles.
- VID_BURST, 8, maximum consecutive video grants while a CPU request is pending (legal 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- cpu_adr  in  24  CPU byte address
- cpu_rd  in  1  CPU read request, held until a cycle with cpu_stall low
- cpu_wr  in  1  CPU write request, same holding rule
- cpu_ben  in  1  byte access (1) / word access (0)
- cpu_wdata  in  32  write data, byte lanes already placed by CPU
- cpu_rdata  out  32  read data, valid in completion cycle
- cpu_stall  out  1  CPU must hold request and wait
- vid_req  in  1  video word request, held until vid_ack
- vid_adr  in  22  video word address
- vid_ack  out  1  one-cycle completion pulse
- vid_data  out  32  read word, valid while vid_ack high
- mem_adr  out  22  RAM word address
- mem_ce  out  1  RAM chip enable
- mem_we  out  1  RAM write enable
- mem_be  out  4  RAM byte-lane enables
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data

Behaviour:
- FSM states are IDLE, ACCESS and DONE; a register `owner` holds CPU or VID.
- Reset: state IDLE, owner CPU, mem_ce=0, mem_we=0, mem_be=0, mem_adr=0, mem_wdata=0, cpu_rdata=0, vid_data=0, vid_ack=0, vcount=0, wait counter 0.
- Reset mid-access abandons the access immediately: no ack, no data capture.

IDLE arbitration (evaluated each cycle in IDLE):
- If vid_req and vcount<VID_BURST, grant VID.
- Else if cpu_rd|cpu_wr, grant CPU.
- Else if vid_req, grant VID (limit reached but no CPU waiting).
- Else stay in IDLE.

On grant:
- Register mem_adr (vid_adr, or cpu_adr[23:2]).
- Register mem_we = CPU & cpu_wr, and mem_wdata = cpu_wdata.
- Register mem_be: 4'b1111 for video or word access; for byte access, the one-hot lane selected by cpu_adr[1:0] (00→0001, 11→1000).
- Load wait counter with MEM_WAIT; go to ACCESS.

vcount:
- +1 on each VID grant, saturating at VID_BURST.
- Cleared on a CPU grant, and on any IDLE cycle with no request.

ACCESS:
- mem_ce=1 and mem_we held for every ACCESS cycle; signals are stable for MEM_WAIT+1 cycles.
- The counter decrements each cycle.
- In the cycle the counter is 0: capture mem_rdata into cpu_rdata (owner CPU, read) or vid_data (owner VID), then go to DONE.
- For a CPU write, cpu_rdata is unchanged.

DONE (one cycle, then IDLE):
- mem_ce=0, mem_we=0.
- Owner VID: vid_ack=1 for this cycle only.
- Owner CPU: cpu_stall=0 in this cycle.

cpu_stall:
- Combinational: (cpu_rd|cpu_wr) & ~(state==DONE & owner==CPU).
- Depends on registered state only; no path from mem_rdata.
- Low whenever there is no CPU request.

CPU latency:
- Request seen at cycle t in IDLE completes at t+2+MEM_WAIT (cycle t+3 for default parameters).
- If video holds the RAM, completion is delayed by whole video accesses.

Boundary and protocol rules:
- A CPU request still asserted in the cycle after DONE is a new access.
- Simultaneous cpu_rd and cpu_wr: treated as a write.
- vid_req deasserted mid-access: the access still completes and vid_ack still pulses.
- Addresses are sampled only at grant; later changes are ignored until the next grant.
- mem_adr wraps naturally at 22 bits; no range checking.

Test Plan:
- CPU word read at cpu_adr=24'h000104, MEM_WAIT=1, RAM word 0x41 = 32'hDEADBEEF, no video → mem_adr=22'h41 and mem_ce=1 for 2 cycles, cpu_stall high for 3 cycles then low with cpu_rdata=32'hDEADBEEF, mem_we=0 throughout.
- CPU byte write at cpu_adr=24'h000203, cpu_wdata=32'h77777777 → mem_be=4'b1000, mem_we=1 for exactly 2 cycles, mem_adr=22'h80; only byte 3 of word 0x80 changes.
- vid_req held continuously with CPU read pending from the same cycle, VID_BURST=8 → exactly 8 vid_ack pulses (4 cycles apart), then one CPU access, then video resumes with vcount restarting at 1.
- vid_req alone for 20 words, no CPU request → 20 consecutive video grants with no gap beyond IDLE/DONE; vid_data matches RAM contents at each ack.
- rst asserted during the second ACCESS cycle of a video read → next cycle state IDLE, mem_ce=0, no vid_ack; a CPU request then proceeds normally.
- MEM_WAIT=0 with a CPU read → mem_ce high 1 cycle, cpu_stall high 2 cycles, data correct.
